// File: rtl/led_boot_pkg.sv
// Shared definitions for the power-up LED sequencer: state encoding and the
// default step length (1 s at 60 MHz).
package led_boot_pkg;

    localparam int unsigned STEP_CYC_DEF = 60_000_000;

    typedef enum logic [1:0] {
        ST_ON    = 2'd0,
        ST_CHASE = 2'd1,
        ST_OFF   = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

endpackage

// File: rtl/led_boot_seq_step_timer.sv
// Step timer: counts 0..CYC-1 while enabled, wraps to 0 after the terminal
// count, and can be cleared synchronously.
module step_timer
    import led_boot_pkg::*;
#(
    parameter int unsigned CYC = STEP_CYC_DEF
) (
    input  logic i_clk,
    input  logic i_res_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int unsigned W = $clog2(CYC);
    localparam logic [W-1:0] LAST = W'(CYC - 1);

    logic [W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            cnt <= '0;
        end else if (i_clr) begin
            cnt <= '0;
        end else if (i_en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
        end
    end

    assign o_tc = (cnt == LAST);

endmodule

// File: rtl/led_boot_seq.sv
// Power-up LED sequencer: ON -> CHASE -> OFF -> RUN, then functional passthrough.
// The chase phase is compiled only when LED_BOOT_CHASE_EN is defined.
module led_boot_seq
    import led_boot_pkg::*;
#(
    parameter int unsigned NUM_LED  = 4,
    parameter int unsigned STEP_CYC = STEP_CYC_DEF,
    parameter bit          ACT_LOW  = 1'b0
) (
    input  logic               i_clk,
    input  logic               i_res_n,
    input  logic               i_restart,
    input  logic [NUM_LED-1:0] i_led,
    output logic [NUM_LED-1:0] o_led,
    output logic               o_busy,
    output logic               o_done
);

    localparam logic [NUM_LED-1:0] POL_MASK = ACT_LOW ? '1 : '0;

    state_t             state, state_nxt;
    logic               tc;
    logic               done_nxt, done_q;
    logic [NUM_LED-1:0] pat_nxt, led_q;

`ifdef LED_BOOT_CHASE_EN
    localparam int unsigned IDX_W = (NUM_LED > 1) ? $clog2(NUM_LED) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_LED - 1);

    logic [IDX_W-1:0] idx, idx_nxt;
`endif

    step_timer #(.CYC(STEP_CYC)) u_step_timer (
        .i_clk   (i_clk),
        .i_res_n (i_res_n),
        .i_clr   (i_restart),
        .i_en    (state != ST_RUN),
        .o_tc    (tc)
    );

    // NOTE: every signal written here gets its default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
`ifdef LED_BOOT_CHASE_EN
        idx_nxt   = idx;
`endif
        if (i_restart) begin
            state_nxt = ST_ON;
`ifdef LED_BOOT_CHASE_EN
            idx_nxt   = '0;
`endif
        end else if (tc) begin
            case (state)
`ifdef LED_BOOT_CHASE_EN
                ST_ON: begin
                    state_nxt = ST_CHASE;
                    idx_nxt   = '0;
                end
                ST_CHASE: begin
                    if (idx < IDX_LAST) idx_nxt = idx + IDX_W'(1);
                    else                state_nxt = ST_OFF;
                end
`else
                ST_ON:    state_nxt = ST_OFF;
`endif
                ST_OFF: begin
                    state_nxt = ST_RUN;
                    done_nxt  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Pattern is registered from the next state so non-RUN outputs come
    // straight from flops and never glitch.
    always_comb begin
        pat_nxt = '0;
        case (state_nxt)
            ST_ON:    pat_nxt = '1;
`ifdef LED_BOOT_CHASE_EN
            ST_CHASE: pat_nxt = NUM_LED'(1) << idx_nxt;
`endif
            default:  pat_nxt = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            state  <= ST_ON;
            done_q <= 1'b0;
            led_q  <= ~POL_MASK;
        end else begin
            state  <= state_nxt;
            done_q <= done_nxt;
            led_q  <= pat_nxt ^ POL_MASK;
        end
    end

`ifdef LED_BOOT_CHASE_EN
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) idx <= '0;
        else          idx <= idx_nxt;
    end
`endif

    assign o_led  = (state == ST_RUN) ? i_led : led_q;
    assign o_busy = (state != ST_RUN);
    assign o_done = done_q;

endmodule

// File: tb/tb_led_boot_seq.sv
// Scoreboard bench for led_boot_seq: three instances (3 LEDs, 3 LEDs active-low,
// 1 LED) with STEP_CYC=4 driven by one directed sequence.
module tb_led_boot_seq;

    localparam int STEP = 4;

    typedef struct {
        logic [2:0] led_a;
        logic [2:0] led_b;
        logic       led_c;
        logic       busy_a, done_a;
        logic       busy_b, done_b;
        logic       busy_c, done_c;
    } exp_t;

    logic       i_clk = 1'b0;
    logic       i_res_n = 1'b0;
    logic       i_restart = 1'b0;
    logic [2:0] i_led = 3'b101;

    logic [2:0] led_a, led_b;
    logic [0:0] led_c;
    logic       busy_a, done_a, busy_b, done_b, busy_c, done_c;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   c = 0;

    always #5 i_clk = ~i_clk;

    led_boot_seq #(.NUM_LED(3), .STEP_CYC(STEP), .ACT_LOW(1'b0)) dut_a (
        .i_clk(i_clk), .i_res_n(i_res_n), .i_restart(i_restart), .i_led(i_led),
        .o_led(led_a), .o_busy(busy_a), .o_done(done_a)
    );

    led_boot_seq #(.NUM_LED(3), .STEP_CYC(STEP), .ACT_LOW(1'b1)) dut_b (
        .i_clk(i_clk), .i_res_n(i_res_n), .i_restart(i_restart), .i_led(i_led),
        .o_led(led_b), .o_busy(busy_b), .o_done(done_b)
    );

    led_boot_seq #(.NUM_LED(1), .STEP_CYC(STEP), .ACT_LOW(1'b0)) dut_c (
        .i_clk(i_clk), .i_res_n(i_res_n), .i_restart(i_restart), .i_led(i_led[0:0]),
        .o_led(led_c), .o_busy(busy_c), .o_done(done_c)
    );

    function automatic int boot_len(input int n);
`ifdef LED_BOOT_CHASE_EN
        return (n + 2) * STEP;
`else
        return 2 * STEP;
`endif
    endfunction

    function automatic logic [2:0] exp_led(input int n, input int cyc,
                                           input logic [2:0] il, input bit act_low);
        logic [2:0] mask;
        logic [2:0] p;
        int         ph;
        mask = (3'b001 << n) - 3'b001;
        if (cyc >= boot_len(n)) return il & mask;
        ph = cyc / STEP;
        if (ph == 0) p = mask;
`ifdef LED_BOOT_CHASE_EN
        else if (ph <= n) p = 3'b001 << (ph - 1);
`endif
        else p = 3'b000;
        return act_low ? (~p & mask) : p;
    endfunction

    function automatic exp_t make_exp(input logic [2:0] il);
        exp_t e;
        logic [2:0] lc;
        e.led_a  = exp_led(3, c, il, 1'b0);
        e.led_b  = exp_led(3, c, il, 1'b1);
        lc       = exp_led(1, c, il, 1'b0);
        e.led_c  = lc[0];
        e.busy_a = (c < boot_len(3));
        e.done_a = (c == boot_len(3));
        e.busy_b = e.busy_a;
        e.done_b = e.done_a;
        e.busy_c = (c < boot_len(1));
        e.done_c = (c == boot_len(1));
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s c=%0d: observed=%0h expected=%0h", tag, c, obs, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, compare 1 ns later, advance.
    task automatic cycle(input logic r, input logic [2:0] il);
        exp_t e;
        i_restart = r;
        i_led     = il;
        sb.push_back(make_exp(il));
        #1;
        e = sb.pop_front();
        check("led_a",  {29'd0, led_a},  {29'd0, e.led_a});
        check("led_b",  {29'd0, led_b},  {29'd0, e.led_b});
        check("led_c",  {31'd0, led_c},  {31'd0, e.led_c});
        check("busy_a", {31'd0, busy_a}, {31'd0, e.busy_a});
        check("done_a", {31'd0, done_a}, {31'd0, e.done_a});
        check("busy_b", {31'd0, busy_b}, {31'd0, e.busy_b});
        check("done_b", {31'd0, done_b}, {31'd0, e.done_b});
        check("busy_c", {31'd0, busy_c}, {31'd0, e.busy_c});
        check("done_c", {31'd0, done_c}, {31'd0, e.done_c});
        @(posedge i_clk);
        c = r ? 0 : c + 1;
        @(negedge i_clk);
    endtask

    // Asynchronous reset: outputs must snap to reset values before any edge.
    task automatic apply_reset();
        i_restart = 1'b0;
        i_res_n   = 1'b0;
        #1;
        check("rst_led_a",  {29'd0, led_a},  32'h7);
        check("rst_led_b",  {29'd0, led_b},  32'h0);
        check("rst_led_c",  {31'd0, led_c},  32'h1);
        check("rst_busy_a", {31'd0, busy_a}, 32'h1);
        check("rst_done_a", {31'd0, done_a}, 32'h0);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_res_n = 1'b1;
        c = 0;
    endtask

    initial begin
        @(negedge i_clk);
        apply_reset();

        // Full boot with i_led=101, then passthrough change to 011 in RUN.
        repeat (24) cycle(1'b0, 3'b101);
        repeat (4)  cycle(1'b0, 3'b011);

        // Restart from RUN, then a restart pulse mid-chase (c == 10).
        cycle(1'b1, 3'b011);
        while (c != 10) cycle(1'b0, 3'b110);
        cycle(1'b1, 3'b110);

        // Restart coinciding with the OFF terminal count (c == 19).
        while (c != 19) cycle(1'b0, 3'b110);
        cycle(1'b1, 3'b110);

        // Restart held high for several cycles keeps the block in ON.
        repeat (3) cycle(1'b1, 3'b010);

        // Asynchronous reset mid-chase, then a full boot again.
        while (c != 6) cycle(1'b0, 3'b101);
        apply_reset();
        repeat (26) cycle(1'b0, 3'b111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_boot_seq.md
# led_boot_seq

Parametrised power-up LED sequencer for N indicator LEDs. After reset it steps through a fixed self-test pattern: all on, a one-hot chase across the LEDs, then all off. It then hands the LEDs over to the functional drivers. It sits between the link-status logic and the top-level LED pins and can be re-run at any time with a restart request.

## Interface
- `NUM_LED`, default 4: number of LEDs, ≥1.
- `STEP_CYC`, default 60_000_000: clock cycles per sequence step, ≥2 (1 s at 60 MHz).
- `ACT_LOW`, default 0: when 1, pattern outputs are inverted for active-low LEDs. `RUN` passthrough is never inverted.
- `i_clk`, in, 1: system clock. One clock domain only.
- `i_res_n`, in, 1: reset, asynchronous, active-low.
- `i_restart`, in, 1: synchronous single-cycle request to restart the sequence.
- `i_led`, in, NUM_LED: functional LED drive, passed through in `RUN`.
- `o_led`, out, NUM_LED: LED drive.
- `o_busy`, out, 1: high while the sequence is running (any state other than `RUN`).
- `o_done`, out, 1: one-cycle pulse in the first cycle of `RUN`.

## Operation
- States: `ST_ON`, `ST_CHASE`, `ST_OFF`, `ST_RUN`.
- Step counter:
  - Width is `$clog2(STEP_CYC)`.
  - Counts 0..STEP_CYC-1 and is cleared on every state or chase-index change.
  - A terminal count `tc` occurs when count == STEP_CYC-1.
- Chase index: width `$clog2(NUM_LED)`, minimum 1.
- Transitions, all taken at `tc`:
  - `ST_ON` → `ST_CHASE`, with index 0.
  - `ST_CHASE`: if index < NUM_LED-1, increment the index; otherwise go to `ST_OFF`.
  - `ST_OFF` → `ST_RUN`.
  - `ST_RUN` is held indefinitely. The counter is frozen at 0 in `ST_RUN`.
- Output pattern before the `ACT_LOW` inversion:
  - `ST_ON`: all ones.
  - `ST_CHASE`: `1 << index`.
  - `ST_OFF`: all zeros.
  - `ST_RUN`: `i_led`, passed through unmodified.
- `i_restart` high in any state: next state is `ST_ON`, counter 0, index 0.
  - Restart has priority over `tc`.
  - Restart held high keeps the block in `ST_ON` with the counter at 0.
- `o_busy` = (state != `ST_RUN`).
- `o_done` is registered and is high exactly in the first `ST_RUN` cycle. It does not fire again until a restart completes.

## Timing
- Reset values:
  - state `ST_ON`, counter 0, index 0.
  - `o_led` = all ones (all zeros if `ACT_LOW`).
  - `o_busy` = 1, `o_done` = 0.
- Cycle 0 is the first rising edge after `i_res_n` deasserts.
- Phase windows:
  - `ST_ON` occupies cycles 0..STEP_CYC-1.
  - Chase LED k is lit for cycles (1+k)·STEP_CYC .. (2+k)·STEP_CYC-1.
  - `ST_OFF` lasts STEP_CYC cycles.
  - `ST_RUN` starts at cycle (NUM_LED+2)·STEP_CYC.
- `o_led` in `ST_RUN`: combinational from `i_led`, zero latency.
- `o_led` in other states: decoded from registers only, glitch-free per state.
- Restart sampled at edge t: `ST_ON` is visible from t+1, and `ST_RUN` is reached (NUM_LED+2)·STEP_CYC cycles after the last cycle `i_restart` is high.
- Reset asserted mid-sequence or in `ST_RUN`: the block returns to reset values immediately and asynchronously.
- NUM_LED=1: the chase is a single step with LED 0 lit.

## Configuration
- `LED_BOOT_CHASE_EN` defined:
  - The full sequence is ON → CHASE → OFF → RUN.
  - Total boot length is (NUM_LED+2)·STEP_CYC cycles.
- `LED_BOOT_CHASE_EN` undefined:
  - `ST_CHASE` and the index register are not compiled.
  - `ST_ON` goes directly to `ST_OFF`.
  - Total boot length is 2·STEP_CYC cycles, which matches the legacy two-step behaviour.

## Structure
- Shared package `led_boot_pkg`:
  - state encoding localparams: `ST_ON`=2'd0, `ST_CHASE`=2'd1, `ST_OFF`=2'd2, `ST_RUN`=2'd3;
  - the STEP_CYC default constant.
- Sub-module `step_timer`:
  - parameter CYC;
  - inputs `i_clr` and `i_en`;
  - output `o_tc`.
  - Instantiated once as the step counter.
- The top level holds the FSM, the chase index, the output decode and the `o_done` register.

## Test plan
All cases use NUM_LED=3 and STEP_CYC=4 with `LED_BOOT_CHASE_EN` defined unless stated otherwise.
- Reset release, `i_led`=3'b101:
  - `o_led` = 111 for cycles 0–3;
  - then 001, 010, 100 in 4-cycle windows at cycles 4, 8, 12;
  - 000 for cycles 16–19;
  - 101 from cycle 20, with `o_done`=1 only in cycle 20 and `o_busy`=0 from cycle 20.
- In `ST_RUN`, change `i_led` from 101 to 011: `o_led` = 011 in the same cycle, with no registered delay.
- `i_restart` pulsed at cycle 10, mid-chase: `o_led` = 111 at cycles 11–14, and `ST_RUN` is reached at cycle 31.
- `i_restart` on the cycle of an `ST_OFF` terminal count: the block enters `ST_ON`, not `ST_RUN`, and `o_done` stays 0.
- `i_res_n` asserted low at cycle 6 for 2 cycles: `o_led` = 111 immediately, and the sequence restarts from cycle 0 after release.
- `LED_BOOT_CHASE_EN` undefined, or `ACT_LOW`=1:
  - undefined macro: `o_led` 111 (cycles 0–3), 000 (cycles 4–7), then `i_led` from cycle 8;
  - `ACT_LOW`=1: patterns are inverted (000 / 110…), while the passthrough is unchanged.
